// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
//   Shared definitions for the multicycle MIPS main control FSM:
//   state encodings, opcode constants, ALUOp codes, datapath mux
//   select codes and the packed control word produced by the output
//   decoder.
//   Optional feature macro: MULTICYCLE_ADDI_EN (adds ADDI_EX/ADDI_WB).
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECUTE  = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_ADDI_EX  = 4'd11,
        S_ADDI_WB  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUB_REG    = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_BRANCH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// mc_output_decode
//   Purely combinational state -> control word decoder for the
//   multicycle MIPS controller. Every field defaults to 0, so a state
//   only lists the signals it asserts.
//   Ports:
//     state     in   current FSM state
//     mem_ready in   memory handshake (gates ir_write/pc_write in FETCH)
//     ctrl      out  packed control word
//   Optional feature macro: MULTICYCLE_ADDI_EN (decodes ADDI_EX/ADDI_WB).
module mc_output_decode
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = ALUB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // The only Mealy outputs: IR and PC load on the cycle the
                // instruction word actually arrives.
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = ALUB_BRANCH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = ALUB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
`ifdef MULTICYCLE_ADDI_EN
            S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
//   Main control FSM for the multicycle MIPS datapath. Sequences fetch,
//   decode, execute, memory and writeback for R-type, lw, sw, beq and j,
//   stalls on mem_ready and counts retired instructions.
//   Ports:
//     clk, rst_n            clock (rising edge), async active-low reset
//     opcode                IR[31:26], valid from DECODE onward
//     mem_ready             memory completes the current access
//     pc_write .. pc_source datapath control word (from mc_output_decode)
//     illegal_op            one-cycle pulse after DECODE of an unsupported opcode
//     retired               instructions completed since reset (wraps)
//     state_dbg             current state encoding
//   Optional feature macro: MULTICYCLE_ADDI_EN (adds addi support).
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state_dbg
);

    state_t state;
    ctrl_t  ctrl;

    // State register, next-state logic, retire counter and the illegal
    // opcode flag. The counter bumps on the last cycle of each legal
    // instruction so it reads the new total on the following FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            retired    <= '0;
            illegal_op <= 1'b0;
        end else begin
            illegal_op <= 1'b0;
            case (state)
                S_IDLE:  state <= S_FETCH;
                S_FETCH: if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_RTYPE:     state <= S_EXECUTE;
                        OP_BEQ:       state <= S_BRANCH;
                        OP_J:         state <= S_JUMP;
`ifdef MULTICYCLE_ADDI_EN
                        OP_ADDI:      state <= S_ADDI_EX;
`endif
                        default: begin
                            state      <= S_FETCH;
                            illegal_op <= 1'b1;
                        end
                    endcase
                end
                // Only lw and sw reach MEMADR, so anything but sw is a load.
                S_MEMADR: state <= (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD: if (mem_ready) state <= S_MEMWB;
                S_MEMWRITE: begin
                    if (mem_ready) begin
                        state   <= S_FETCH;
                        retired <= retired + CNT_W'(1);
                    end
                end
                S_EXECUTE: state <= S_ALUWB;
                S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP: begin
                    state   <= S_FETCH;
                    retired <= retired + CNT_W'(1);
                end
`ifdef MULTICYCLE_ADDI_EN
                S_ADDI_EX: state <= S_ADDI_WB;
                S_ADDI_WB: begin
                    state   <= S_FETCH;
                    retired <= retired + CNT_W'(1);
                end
`endif
                default: state <= S_FETCH;
            endcase
        end
    end

    mc_output_decode u_decode (
        .state     (state),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign state_dbg     = state;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//   Scoreboard bench for multicycle_control. The stimulus process expands
//   each instruction into its phase list (with random memory stalls),
//   drives opcode/mem_ready per cycle and queues the expected state,
//   control word, illegal_op and retired count. A monitor pops one entry
//   per cycle and compares on the falling edge.
//   A narrow retire counter is used so wrap-around is exercised.
//   Optional feature macro: MULTICYCLE_ADDI_EN (addi expected legal).
module tb_multicycle_control;

    localparam int CNT_W = 4;

`ifdef MULTICYCLE_ADDI_EN
    localparam bit ADDI_LEGAL = 1'b1;
`else
    localparam bit ADDI_LEGAL = 1'b0;
`endif

    localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3, ST_MEMREAD = 4'd4, ST_MEMWB = 4'd5, ST_MEMWRITE = 4'd6,
        ST_EXECUTE = 4'd7, ST_ALUWB = 4'd8, ST_BRANCH = 4'd9, ST_JUMP = 4'd10,
        ST_ADDI_EX = 4'd11, ST_ADDI_WB = 4'd12;

    localparam int C_LW = 0, C_SW = 1, C_R = 2, C_BEQ = 3, C_J = 4, C_ADDI = 5, C_ILL = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic             mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]       alu_src_b, alu_op, pc_source;
    logic             illegal_op;
    logic [CNT_W-1:0] retired;
    logic [3:0]       state_dbg;

    always #5 clk = ~clk;

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .retired       (retired),
        .state_dbg     (state_dbg)
    );

    typedef struct {
        logic [3:0]       st;
        logic [15:0]      word;
        logic             ill;
        logic [CNT_W-1:0] ret;
    } rec_t;

    rec_t expQ[$];
    int   testsRun = 0;
    int   testsFailed = 0;
    int   modelRetired = 0;
    bit   pendingIllegal = 1'b0;
    int   cyc = 0;

    // Control word packing shared by expectation and observation:
    // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
    //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
    function automatic logic [15:0] mkWord(input logic pcw, input logic pcwc, input logic io,
                                           input logic mr, input logic mw, input logic irw,
                                           input logic m2r, input logic rd, input logic rw,
                                           input logic asa, input logic [1:0] asb,
                                           input logic [1:0] aop, input logic [1:0] psrc);
        return {pcw, pcwc, io, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc};
    endfunction

    function automatic logic [15:0] phaseWord(input logic [3:0] st, input logic rdy);
        case (st)
            ST_FETCH:    return mkWord(rdy,0,0,1,0,rdy,0,0,0,0,2'b01,2'b00,2'b00);
            ST_DECODE:   return mkWord(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00);
            ST_MEMADR:   return mkWord(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00);
            ST_MEMREAD:  return mkWord(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00);
            ST_MEMWB:    return mkWord(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00);
            ST_MEMWRITE: return mkWord(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00);
            ST_EXECUTE:  return mkWord(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00);
            ST_ALUWB:    return mkWord(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00);
            ST_BRANCH:   return mkWord(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01);
            ST_JUMP:     return mkWord(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10);
            ST_ADDI_EX:  return mkWord(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00);
            ST_ADDI_WB:  return mkWord(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00);
            default:     return 16'h0000;
        endcase
    endfunction

    function automatic int classOf(input logic [5:0] op);
        case (op)
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000000: return C_R;
            6'b000100: return C_BEQ;
            6'b000010: return C_J;
            6'b001000: return ADDI_LEGAL ? C_ADDI : C_ILL;
            default:   return C_ILL;
        endcase
    endfunction

    // Drive one cycle's inputs just after the rising edge and queue what
    // the DUT must show during that cycle.
    task automatic applyStimulus(input logic [5:0] op, input logic rdy, input logic [3:0] st);
        rec_t r;
        @(posedge clk);
        #1;
        opcode    = op;
        mem_ready = rdy;
        r.st   = st;
        r.word = phaseWord(st, rdy);
        r.ill  = pendingIllegal;
        r.ret  = CNT_W'(modelRetired);
        expQ.push_back(r);
        pendingIllegal = 1'b0;
    endtask

    task automatic pushIdle();
        rec_t r;
        r.st   = ST_IDLE;
        r.word = 16'h0000;
        r.ill  = 1'b0;
        r.ret  = '0;
        expQ.push_back(r);
    endtask

    task automatic doReset(input int lowCycles);
        for (int i = 0; i < lowCycles; i++) begin
            @(posedge clk);
            #1;
            rst_n          = 1'b0;
            mem_ready      = 1'(($urandom % 2));
            modelRetired   = 0;
            pendingIllegal = 1'b0;
            pushIdle();
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pushIdle();
    endtask

    task automatic memPhase(input logic [5:0] op, input logic [3:0] st, input int stall);
        for (int i = 0; i < stall; i++) applyStimulus(op, 1'b0, st);
        applyStimulus(op, 1'b1, st);
    endtask

    task automatic runInstr(input logic [5:0] op, input int fetchStall, input int memStall);
        memPhase(op, ST_FETCH, fetchStall);
        applyStimulus(op, 1'(($urandom % 2)), ST_DECODE);
        case (classOf(op))
            C_LW: begin
                applyStimulus(op, 1'(($urandom % 2)), ST_MEMADR);
                memPhase(op, ST_MEMREAD, memStall);
                applyStimulus(op, 1'(($urandom % 2)), ST_MEMWB);
                modelRetired++;
            end
            C_SW: begin
                applyStimulus(op, 1'(($urandom % 2)), ST_MEMADR);
                memPhase(op, ST_MEMWRITE, memStall);
                modelRetired++;
            end
            C_R: begin
                applyStimulus(op, 1'(($urandom % 2)), ST_EXECUTE);
                applyStimulus(op, 1'(($urandom % 2)), ST_ALUWB);
                modelRetired++;
            end
            C_BEQ: begin
                applyStimulus(op, 1'(($urandom % 2)), ST_BRANCH);
                modelRetired++;
            end
            C_J: begin
                applyStimulus(op, 1'(($urandom % 2)), ST_JUMP);
                modelRetired++;
            end
            C_ADDI: begin
                applyStimulus(op, 1'(($urandom % 2)), ST_ADDI_EX);
                applyStimulus(op, 1'(($urandom % 2)), ST_ADDI_WB);
                modelRetired++;
            end
            default: pendingIllegal = 1'b1;
        endcase
    endtask

    task automatic checkOutput(input rec_t r);
        logic [15:0] act;
        act = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
        testsRun += 4;
        if (state_dbg !== r.st) begin
            testsFailed++;
            $display("[TB] FAIL state cycle %0d: got %0d expected %0d", cyc, state_dbg, r.st);
        end
        if (act !== r.word) begin
            testsFailed++;
            $display("[TB] FAIL ctrl_word cycle %0d: got %h expected %h", cyc, act, r.word);
        end
        if (illegal_op !== r.ill) begin
            testsFailed++;
            $display("[TB] FAIL illegal_op cycle %0d: got %b expected %b", cyc, illegal_op, r.ill);
        end
        if (retired !== r.ret) begin
            testsFailed++;
            $display("[TB] FAIL retired cycle %0d: got %0d expected %0d", cyc, retired, r.ret);
        end
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin
        int ops[7];
        int pick;
        logic [5:0] op;
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        opcode    = 6'd0;
        ops = '{35, 43, 0, 4, 2, 8, 0};

        doReset(2);
        runInstr(6'b100011, 0, 0);          // lw, no stalls
        runInstr(6'b101011, 0, 3);          // sw, 3 stall cycles in MEMWRITE
        runInstr(6'b000000, 0, 0);          // R-type
        runInstr(6'b000100, 0, 0);          // beq back to back
        runInstr(6'b111111, 0, 0);          // illegal
        runInstr(6'b000010, 2, 0);          // j with fetch stalls
        runInstr(6'b001000, 0, 0);          // addi (legal only with feature)

        // Reset asserted while a load waits in MEMREAD.
        memPhase(6'b100011, ST_FETCH, 0);
        applyStimulus(6'b100011, 1'b0, ST_DECODE);
        applyStimulus(6'b100011, 1'b1, ST_MEMADR);
        applyStimulus(6'b100011, 1'b0, ST_MEMREAD);
        doReset(2);

        for (int n = 0; n < 150; n++) begin
            pick = int'($urandom_range(0, 6));
            if (pick == 6) op = 6'($urandom_range(0, 63));
            else           op = 6'(ops[pick]);
            runInstr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end
        applyStimulus(6'd0, 1'b0, ST_FETCH);

        for (int w = 0; w < 10 && expQ.size() > 0; w++) @(negedge clk);
        @(negedge clk);
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL drain: got %0d pending records expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
